// File: rtl/emmc_cmd_phy.sv
// emmc_cmd_phy
// Bit-level engine for the eMMC CMD line. Serializes a 48-bit command frame
// (start, transmission bit, index, argument, CRC7, end bit), releases the line
// to the card and then captures a 48- or 136-bit response, checking the end
// bit and, for 48-bit responses with CRC, the CRC7 field.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   sd_clk_en       one-cycle strobe marking each card-clock bit boundary
//   cmd_valid/ready command handshake; ready is high only while idle
//   cmd_index       6-bit command index
//   cmd_arg         32-bit command argument
//   resp_type       00 none, 01 48-bit + CRC, 10 136-bit, 11 48-bit no CRC
//   done            one-cycle completion pulse
//   resp_data       captured response, right-aligned, held until next command
//   resp_crc_err    CRC or end-bit error, valid from done
//   resp_timeout    no response start bit within TIMEOUT_CYCLES strobes
//   cmd_o_out       to tristate buffer data input
//   cmd_o_oe        to tristate buffer output enable
//   cmd_i           pad readback from tristate buffer
module emmc_cmd_phy #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sd_clk_en,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    output logic         done,
    output logic [127:0] resp_data,
    output logic         resp_crc_err,
    output logic         resp_timeout,
    output logic         cmd_o_out,
    output logic         cmd_o_oe,
    input  logic         cmd_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_RESP = 3'd2,
        S_RECV      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        crc7_step = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    // Full command frame: start, transmission bit, index, arg, CRC7, end bit.
    function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        logic [6:0]  crc;
        head = {1'b0, 1'b1, idx, arg};
        crc  = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            crc = crc7_step(crc, head[i]);
        end
        build_frame = {head, crc, 1'b1};
    endfunction

    state_t       state_r;
    logic [46:0]  frame_r;      // bits still to be sent after the one on the line
    logic [5:0]   bit_cnt_r;
    logic [1:0]   rtype_r;
    logic [TW-1:0] to_cnt_r;
    logic [7:0]   rx_cnt_r;     // bits received after the start bit
    logic [6:0]   rx_crc_r;
    logic [47:0]  new_frame_s;
    logic [7:0]   rx_last_s;

    assign new_frame_s = build_frame(cmd_index, cmd_arg);
    // Index of the end bit among the bits following the response start bit.
    assign rx_last_s   = (rtype_r == 2'b10) ? 8'd134 : 8'd46;

    // Command/response sequencer with registered line and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            frame_r      <= 47'd0;
            bit_cnt_r    <= 6'd0;
            rtype_r      <= 2'b00;
            to_cnt_r     <= '0;
            rx_cnt_r     <= 8'd0;
            rx_crc_r     <= 7'd0;
            cmd_ready    <= 1'b1;
            done         <= 1'b0;
            resp_data    <= 128'd0;
            resp_crc_err <= 1'b0;
            resp_timeout <= 1'b0;
            cmd_o_out    <= 1'b1;
            cmd_o_oe     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    done      <= 1'b0;
                    cmd_o_oe  <= 1'b0;
                    cmd_o_out <= 1'b1;
                    // A strobe in the acceptance cycle is deliberately ignored:
                    // the start bit goes out on the next cycle and lasts a full bit.
                    if (cmd_valid) begin
                        rtype_r      <= resp_type;
                        frame_r      <= new_frame_s[46:0];
                        bit_cnt_r    <= 6'd47;
                        resp_data    <= 128'd0;
                        resp_crc_err <= 1'b0;
                        resp_timeout <= 1'b0;
                        cmd_ready    <= 1'b0;
                        cmd_o_oe     <= 1'b1;
                        cmd_o_out    <= new_frame_s[47];
                        state_r      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (sd_clk_en) begin
                        if (bit_cnt_r == 6'd0) begin
                            cmd_o_oe  <= 1'b0;
                            cmd_o_out <= 1'b1;
                            to_cnt_r  <= '0;
                            if (rtype_r == 2'b00) begin
                                done    <= 1'b1;
                                state_r <= S_DONE;
                            end else begin
                                state_r <= S_WAIT_RESP;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r - 6'd1;
                            cmd_o_out <= frame_r[46];
                            frame_r   <= {frame_r[45:0], 1'b0};
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (sd_clk_en) begin
                        if (!cmd_i) begin
                            // The start bit is 0, so seeding the CRC with 0 already
                            // accounts for it.
                            rx_cnt_r <= 8'd0;
                            rx_crc_r <= 7'd0;
                            state_r  <= S_RECV;
                        end else if (to_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                            resp_timeout <= 1'b1;
                            done         <= 1'b1;
                            state_r      <= S_DONE;
                        end else begin
                            to_cnt_r <= to_cnt_r + TW'(1);
                        end
                    end
                end
                S_RECV: begin
                    if (sd_clk_en) begin
                        if (rx_cnt_r == rx_last_s) begin
                            // End bit: not stored. CRC field is the last 7 stored bits.
                            resp_crc_err <= (!cmd_i) ||
                                            ((rtype_r == 2'b01) && (rx_crc_r != resp_data[6:0]));
                            done         <= 1'b1;
                            state_r      <= S_DONE;
                        end else begin
                            resp_data <= {resp_data[126:0], cmd_i};
                            rx_cnt_r  <= rx_cnt_r + 8'd1;
                            if (rx_cnt_r < 8'd39) begin
                                rx_crc_r <= crc7_step(rx_crc_r, cmd_i);
                            end
                        end
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= S_IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    cmd_o_oe  <= 1'b0;
                    cmd_o_out <= 1'b1;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
